// File: rtl/i_cache_refill.sv
// Instruction-cache line refill engine: streams one aligned line from backing memory
// into the cache data array, then pulses done with the line base address.
module i_cache_refill #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned ADD_WIDTH       = 12,
   parameter int unsigned WORDS_PER_LINE  = 4,
   parameter int unsigned CACHE_ADD_WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       miss_req,
   input  logic [ADD_WIDTH-1:0]       miss_addr,
   output logic                       miss_ready,
   output logic                       busy,
   output logic                       done,
   output logic [ADD_WIDTH-1:0]       done_addr,
   output logic                       mem_rden,
   output logic [ADD_WIDTH-1:0]       mem_rdaddress,
   input  logic [DATA_WIDTH-1:0]      mem_data,
   output logic                       cache_wden,
   output logic [CACHE_ADD_WIDTH-1:0] cache_wraddress,
   output logic [DATA_WIDTH-1:0]      cache_data
);

   localparam int unsigned OffW = $clog2(WORDS_PER_LINE);
   localparam logic [ADD_WIDTH-1:0] LineMask = ~ADD_WIDTH'(WORDS_PER_LINE - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRead  = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   logic [1:0]                 state_q, state_d;
   logic [ADD_WIDTH-1:0]       base_q, base_d;
   logic [OffW-1:0]            cnt_q, cnt_d;
   logic [ADD_WIDTH-1:0]       done_addr_q, done_addr_d;
   logic                       wr_en_q;
   logic [CACHE_ADD_WIDTH-1:0] wr_addr_q;
   logic [ADD_WIDTH-1:0]       rd_addr;

   // base is line aligned and cnt_q < WORDS_PER_LINE, so the sum never carries out of the line
   assign rd_addr = base_q + ADD_WIDTH'(cnt_q);

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      cnt_d       = cnt_q;
      done_addr_d = done_addr_q;
      case (state_q)
         StIdle: begin
            if (miss_req) begin
               base_d  = miss_addr & LineMask;
               cnt_d   = '0;
               state_d = StRead;
            end
         end
         StRead: begin
            cnt_d = cnt_q + OffW'(1);
            if (&cnt_q) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            done_addr_d = base_q;
            state_d     = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         base_q      <= '0;
         cnt_q       <= '0;
         done_addr_q <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         cnt_q       <= cnt_d;
         done_addr_q <= done_addr_d;
         // Memory returns data one cycle after the read, so the write trails it by one cycle
         wr_en_q     <= mem_rden;
         wr_addr_q   <= rd_addr[CACHE_ADD_WIDTH-1:0];
      end
   end

   always_comb begin
      miss_ready      = (state_q == StIdle);
      busy            = (state_q != StIdle);
      done            = (state_q == StDone);
      done_addr       = done_addr_q;
      mem_rden        = (state_q == StRead);
      mem_rdaddress   = rd_addr;
      cache_wden      = wr_en_q;
      cache_wraddress = wr_addr_q;
      cache_data      = wr_en_q ? mem_data : '0;
   end

endmodule

// File: tb/tb_i_cache_refill.sv
// Directed bench for i_cache_refill: default geometry plus an 8-word-line instance.
module tb_i_cache_refill;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        miss_req;
   logic [11:0] miss_addr;
   logic        miss_ready, busy, done, mem_rden, cache_wden;
   logic [11:0] done_addr, mem_rdaddress;
   logic [31:0] mem_data;
   logic [7:0]  cache_wraddress;
   logic [31:0] cache_data;

   logic        miss_req8;
   logic [11:0] miss_addr8;
   logic        miss_ready8, busy8, done8, mem_rden8, cache_wden8;
   logic [11:0] done_addr8, mem_rdaddress8;
   logic [31:0] mem_data8;
   logic [7:0]  cache_wraddress8;
   logic [31:0] cache_data8;

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   i_cache_refill u_dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .miss_req        (miss_req),
      .miss_addr       (miss_addr),
      .miss_ready      (miss_ready),
      .busy            (busy),
      .done            (done),
      .done_addr       (done_addr),
      .mem_rden        (mem_rden),
      .mem_rdaddress   (mem_rdaddress),
      .mem_data        (mem_data),
      .cache_wden      (cache_wden),
      .cache_wraddress (cache_wraddress),
      .cache_data      (cache_data)
   );

   i_cache_refill #(.WORDS_PER_LINE(8)) u_dut8 (
      .clock           (clock),
      .reset_n         (reset_n),
      .miss_req        (miss_req8),
      .miss_addr       (miss_addr8),
      .miss_ready      (miss_ready8),
      .busy            (busy8),
      .done            (done8),
      .done_addr       (done_addr8),
      .mem_rden        (mem_rden8),
      .mem_rdaddress   (mem_rdaddress8),
      .mem_data        (mem_data8),
      .cache_wden      (cache_wden8),
      .cache_wraddress (cache_wraddress8),
      .cache_data      (cache_data8)
   );

   // Backing memory: word at address a reads as 0xBEEF0_<a>, one cycle after rden
   always @(posedge clock) begin
      if (mem_rden)  mem_data  <= {20'hBEEF0, mem_rdaddress};
      if (mem_rden8) mem_data8 <= {20'hBEEF0, mem_rdaddress8};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Accept req_addr at edge 0 and check cycles 1..7 of the fill against exp_base.
   // From cycle 1 onward miss_req is driven to hold_req with next_addr on miss_addr.
   task automatic fill(input logic [11:0] req_addr, input logic [11:0] exp_base,
                       input logic hold_req, input logic [11:0] next_addr);
      logic [11:0] a;
      miss_req  = 1'b1;
      miss_addr = req_addr;
      tick();
      for (int c = 1; c <= 6; c++) begin
         chk("busy", busy, 1);
         chk("miss_ready", miss_ready, 0);
         chk("mem_rden", mem_rden, (c <= 4) ? 1 : 0);
         if (c <= 4) begin
            a = exp_base + 12'(c - 1);
            chk("mem_rdaddress", mem_rdaddress, a);
         end
         chk("cache_wden", cache_wden, (c >= 2 && c <= 5) ? 1 : 0);
         if (c >= 2 && c <= 5) begin
            a = exp_base + 12'(c - 2);
            chk("cache_wraddress", cache_wraddress, a[7:0]);
            chk("cache_data", cache_data, {20'hBEEF0, a});
         end
         chk("done", done, (c == 6) ? 1 : 0);
         if (c == 6) chk("done_addr", done_addr, exp_base);
         miss_req  = hold_req;
         miss_addr = next_addr;
         tick();
      end
      chk("ready_after_done", miss_ready, 1);
      chk("done_clear", done, 0);
      chk("done_addr_hold", done_addr, exp_base);
      chk("rden_idle", mem_rden, 0);
      chk("wden_idle", cache_wden, 0);
   endtask

   initial begin
      int rd_cnt, wr_cnt, done_cyc;
      reset_n    = 1'b0;
      miss_req   = 1'b0;
      miss_addr  = 12'h000;
      miss_req8  = 1'b0;
      miss_addr8 = 12'h000;
      #1;
      chk("rst_ready", miss_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rden", mem_rden, 0);
      chk("rst_wden", cache_wden, 0);
      chk("rst_rdaddr", mem_rdaddress, 0);
      chk("rst_wraddr", cache_wraddress, 0);
      chk("rst_done_addr", done_addr, 0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("ready_after_reset", miss_ready, 1);

      // Basic fill; miss_addr changes after acceptance must be ignored
      fill(12'h123, 12'h120, 1'b0, 12'h555);
      // Top of memory, no wrap to 0x000
      fill(12'hFFE, 12'hFFC, 1'b0, 12'h000);
      tick();
      chk("no_phantom_accept", miss_ready, 1);

      // Request held while busy: ignored until the first idle edge after done
      fill(12'h088, 12'h088, 1'b1, 12'h040);
      fill(12'h040, 12'h040, 1'b0, 12'h000);

      // Back-to-back: accepts at cycles 0 and 7, done at 6 and 13
      fill(12'h010, 12'h010, 1'b1, 12'h030);
      fill(12'h030, 12'h030, 1'b0, 12'h000);

      // Reset in cycle 3 of a fill
      miss_req  = 1'b1;
      miss_addr = 12'h300;
      tick();
      miss_req = 1'b0;
      tick();
      tick();
      chk("pre_reset_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", miss_ready, 1);
      chk("mid_rst_rden", mem_rden, 0);
      chk("mid_rst_wden", cache_wden, 0);
      chk("mid_rst_data", cache_data, 0);
      chk("mid_rst_rdaddr", mem_rdaddress, 0);
      chk("mid_rst_wraddr", cache_wraddress, 0);
      chk("mid_rst_done_addr", done_addr, 0);
      tick();
      chk("mid_rst_done", done, 0);
      reset_n = 1'b1;
      tick();
      chk("post_rst_ready", miss_ready, 1);
      chk("post_rst_wden", cache_wden, 0);
      chk("post_rst_done", done, 0);
      fill(12'h200, 12'h200, 1'b0, 12'h000);

      // 8-word line: done at cycle 10, eight reads and eight writes
      rd_cnt    = 0;
      wr_cnt    = 0;
      done_cyc  = 0;
      miss_req8  = 1'b1;
      miss_addr8 = 12'h0A5;
      tick();
      miss_req8 = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (mem_rden8) rd_cnt++;
         if (cache_wden8) wr_cnt++;
         if (done8) begin
            done_cyc = c;
            chk("w8_done_addr", done_addr8, 12'h0A0);
            break;
         end
         tick();
      end
      chk("w8_done_cycle", done_cyc, 10);
      chk("w8_rd_count", rd_cnt, 8);
      chk("w8_wr_count", wr_cnt, 8);
      tick();
      chk("w8_ready", miss_ready8, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
